uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
- Command controller between the UART receive side and the counter/transmit side.
- Decodes single-byte ASCII commands from the UART receiver and drives run/clear controls for the up-counter.
- Sequences one reply byte per command into the UART transmitter, with a start/done handshake and a timeout.
- Replaces the direct rx-to-tx loopback at top level.

Parameters:
- REPLY_EN, 1, 1 = send a reply byte per command; 0 = silent, no tx_start ever.
- ERR_CHAR, 8'h3F, reply byte for an unrecognised command ('?').
- TX_TIMEOUT, 2_000_000, max clocks to wait for tx_done after tx_start; must be ≥ 2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- i_rx_data  input  8  received byte; valid only in the i_rx_done cycle
- i_rx_done  input  1  one-cycle pulse, byte received
- i_tx_done  input  1  one-cycle pulse, transmitter finished the frame
- o_tx_start  output  1  one-cycle pulse, start transmission of o_tx_data
- o_tx_data  output  8  reply byte; held stable from the o_tx_start cycle until the next command
- o_run  output  1  counter enable level
- o_clear  output  1  one-cycle counter clear pulse
- o_busy  output  1  high in any state other than IDLE
- o_overrun  output  1  one-cycle pulse, command byte dropped
- o_tx_timeout  output  1  one-cycle pulse, tx_done not received in time

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE, pending buffer empty, timeout counter 0.
  - All outputs 0; o_tx_data = 8'h00.
  - Reset mid-operation aborts any wait and discards the pending byte; o_run returns to 0.
- States: IDLE, EXEC, WAIT_TX.
- IDLE:
  - If the pending buffer is valid, latch the pending byte into the command register and go to EXEC.
  - Else if i_rx_done, latch i_rx_data and go to EXEC.
  - If both occur in the same cycle, the pending byte executes and the new byte is written to the pending buffer (freed that cycle); no overrun.
- EXEC (exactly 1 cycle). Decode, case-insensitive:
  - 'R'/'r' (8'h52/8'h72): o_run←1; reply 'R'.
  - 'S'/'s' (8'h53/8'h73): o_run←0; reply 'S'.
  - 'C'/'c' (8'h43/8'h63): o_clear pulses 1 cycle; o_run unchanged; reply 'C'.
  - 'T'/'t' (8'h54/8'h74): o_run←~o_run; reply 'R' if new run=1, else 'S'.
  - Any other byte: no control change; reply ERR_CHAR.
  - REPLY_EN=1: o_tx_data←reply and o_tx_start←1 registered on the EXEC edge; go to WAIT_TX.
  - REPLY_EN=0: control change only; go to IDLE.
- Latency: i_rx_done in cycle n (IDLE, pending empty) → o_run/o_clear/o_tx_start/o_tx_data change, visible in cycle n+2; o_tx_start high in cycle n+2 only.
- WAIT_TX:
  - i_tx_done is ignored in the o_tx_start cycle itself.
  - Counter increments each WAIT_TX cycle.
  - i_tx_done → go to IDLE.
  - If the counter reaches TX_TIMEOUT with no i_tx_done: pulse o_tx_timeout, go to IDLE.
  - A late i_tx_done arriving in IDLE is ignored.
- Pending buffer (1 entry), in EXEC/WAIT_TX:
  - i_rx_done with the buffer empty stores the byte.
  - i_rx_done with the buffer full drops the new byte and pulses o_overrun; the stored byte is kept.
- Back-to-back: the pending command enters EXEC the cycle after returning to IDLE.
- o_clear and o_tx_start never last more than 1 cycle.

Test Plan:
- Reset, then rx 8'h72 ('r') at cycle n → o_run=1 and o_tx_start=1 with o_tx_data=8'h52 at n+2; tx_done at n+20 → o_busy=0 at n+21.
- Rx 'C', then tx_done → o_clear high exactly 1 cycle at n+2; o_run unchanged; o_tx_data=8'h43.
- Rx 8'h41 ('A') → no run/clear change; o_tx_data=8'h3F.
- Rx 'R', then 'S' and 'C' during WAIT_TX → 'S' buffered; 'C' dropped with o_overrun=1 for 1 cycle; after tx_done, 'S' executes: o_run=0, reply 8'h53.
- Rx 'T' with TX_TIMEOUT=16 and i_tx_done held 0 → o_run toggles; o_tx_timeout pulses after 16 WAIT_TX cycles; state IDLE; a later tx_done has no effect.
- reset=0 asserted in WAIT_TX with a pending byte → next cycle all outputs 0, o_busy=0; no further tx_start after reset release.
- REPLY_EN=0 variant, rx 'r' → o_run=1 at n+2; o_tx_start never asserted.

Source files
------------

// File: rtl/uart_cmd_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_if
// Description : Command/reply handshake bundle between the UART side and the
//               command controller.
// Revision    : 1.0
// ============================================================================
interface uart_cmd_if;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_tx_done;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic       o_run;
    logic       o_clear;
    logic       o_busy;
    logic       o_overrun;
    logic       o_tx_timeout;

    // Controller side.
    modport master (
        input  i_rx_data, i_rx_done, i_tx_done,
        output o_tx_start, o_tx_data, o_run, o_clear, o_busy, o_overrun, o_tx_timeout
    );

    // UART / counter side.
    modport slave (
        output i_rx_data, i_rx_done, i_tx_done,
        input  o_tx_start, o_tx_data, o_run, o_clear, o_busy, o_overrun, o_tx_timeout
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : Decodes single-byte ASCII commands into run/clear controls and
//               sequences one reply byte per command with a tx timeout.
// Revision    : 1.0
// ============================================================================
module uart_cmd_ctrl #(
    parameter bit          REPLY_EN   = 1'b1,
    parameter logic [7:0]  ERR_CHAR   = 8'h3F,
    parameter int unsigned TX_TIMEOUT = 2_000_000
) (
    input  wire logic       clk,
    input  wire logic       reset,
    uart_cmd_if.master      bus
);

    localparam int                 c_CNT_W   = $clog2(TX_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TX_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        WAIT_TX = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_cmd, w_cmd_nxt;
    logic               r_pend_valid, w_pend_valid_nxt;
    logic [7:0]         r_pend_data, w_pend_data_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic               r_run, w_run_nxt;
    logic               r_clear, w_clear_nxt;
    logic               r_tx_start, w_tx_start_nxt;
    logic [7:0]         r_tx_data, w_tx_data_nxt;
    logic               r_overrun, w_overrun_nxt;
    logic               r_timeout, w_timeout_nxt;
    logic [7:0]         w_reply;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_cmd        <= 8'h00;
            r_pend_valid <= 1'b0;
            r_pend_data  <= 8'h00;
            r_cnt        <= '0;
            r_run        <= 1'b0;
            r_clear      <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cmd        <= w_cmd_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_data  <= w_pend_data_nxt;
            r_cnt        <= w_cnt_nxt;
            r_run        <= w_run_nxt;
            r_clear      <= w_clear_nxt;
            r_tx_start   <= w_tx_start_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_overrun    <= w_overrun_nxt;
            r_timeout    <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cmd_nxt        = r_cmd;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_data_nxt  = r_pend_data;
        w_cnt_nxt        = r_cnt;
        w_run_nxt        = r_run;
        w_clear_nxt      = 1'b0;
        w_tx_start_nxt   = 1'b0;
        w_tx_data_nxt    = r_tx_data;
        w_overrun_nxt    = 1'b0;
        w_timeout_nxt    = 1'b0;
        w_reply          = ERR_CHAR;

        case (r_state)
            IDLE: begin
                if (r_pend_valid) begin
                    // Buffered byte runs first; a simultaneous new byte refills the freed slot.
                    w_cmd_nxt        = r_pend_data;
                    w_state_nxt      = EXEC;
                    w_pend_valid_nxt = bus.i_rx_done;
                    if (bus.i_rx_done) begin
                        w_pend_data_nxt = bus.i_rx_data;
                    end
                end else if (bus.i_rx_done) begin
                    w_cmd_nxt   = bus.i_rx_data;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                case (r_cmd)
                    8'h52, 8'h72: begin
                        w_run_nxt = 1'b1;
                        w_reply   = 8'h52;
                    end
                    8'h53, 8'h73: begin
                        w_run_nxt = 1'b0;
                        w_reply   = 8'h53;
                    end
                    8'h43, 8'h63: begin
                        w_clear_nxt = 1'b1;
                        w_reply     = 8'h43;
                    end
                    8'h54, 8'h74: begin
                        w_run_nxt = ~r_run;
                        w_reply   = r_run ? 8'h53 : 8'h52;
                    end
                    default: w_reply = ERR_CHAR;
                endcase
                if (REPLY_EN) begin
                    w_tx_data_nxt  = w_reply;
                    w_tx_start_nxt = 1'b1;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = WAIT_TX;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_TX: begin
                // tx_done coinciding with our own start pulse cannot belong to this frame.
                if (bus.i_tx_done && !r_tx_start) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == c_CNT_MAX) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (r_state != IDLE && bus.i_rx_done) begin
            if (!r_pend_valid) begin
                w_pend_valid_nxt = 1'b1;
                w_pend_data_nxt  = bus.i_rx_data;
            end else begin
                w_overrun_nxt = 1'b1;
            end
        end
    end

    assign bus.o_tx_start   = r_tx_start;
    assign bus.o_tx_data    = r_tx_data;
    assign bus.o_run        = r_run;
    assign bus.o_clear      = r_clear;
    assign bus.o_busy       = (r_state != IDLE);
    assign bus.o_overrun    = r_overrun;
    assign bus.o_tx_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_ctrl
// Description : Directed self-checking bench for uart_cmd_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_uart_cmd_ctrl;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    int         checks  = 0;
    int         errors  = 0;
    logic       nr_start_seen = 1'b0;

    always #5 clk = ~clk;

    uart_cmd_if bus_m ();
    uart_cmd_if bus_t ();
    uart_cmd_if bus_n ();

    assign bus_m.i_rx_data = rx_data;
    assign bus_m.i_rx_done = rx_done;
    assign bus_m.i_tx_done = tx_done;
    assign bus_t.i_rx_data = rx_data;
    assign bus_t.i_rx_done = rx_done;
    assign bus_t.i_tx_done = tx_done;
    assign bus_n.i_rx_data = rx_data;
    assign bus_n.i_rx_done = rx_done;
    assign bus_n.i_tx_done = tx_done;

    uart_cmd_ctrl #(.REPLY_EN(1'b1), .ERR_CHAR(8'h3F), .TX_TIMEOUT(64)) u_dut_m (
        .clk(clk), .reset(reset), .bus(bus_m.master));
    uart_cmd_ctrl #(.REPLY_EN(1'b1), .ERR_CHAR(8'h3F), .TX_TIMEOUT(16)) u_dut_t (
        .clk(clk), .reset(reset), .bus(bus_t.master));
    uart_cmd_ctrl #(.REPLY_EN(1'b0), .ERR_CHAR(8'h3F), .TX_TIMEOUT(16)) u_dut_n (
        .clk(clk), .reset(reset), .bus(bus_n.master));

    always @(negedge clk) begin
        if (bus_n.o_tx_start === 1'b1) nr_start_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse rx_done for one cycle; returns in cycle n+1.
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    initial begin
        logic seen;

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        check("rst_tx_start", bus_m.o_tx_start, 1'b0);
        check("rst_tx_data", bus_m.o_tx_data, 8'h00);
        check("rst_run", bus_m.o_run, 1'b0);
        check("rst_clear", bus_m.o_clear, 1'b0);
        check("rst_busy", bus_m.o_busy, 1'b0);
        check("rst_overrun", bus_m.o_overrun, 1'b0);
        check("rst_timeout", bus_m.o_tx_timeout, 1'b0);
        reset = 1'b1;
        tick();

        // 'r' -> run, reply 'R' at n+2; tx_done at n+20
        send(8'h72);
        check("r_n1_busy", bus_m.o_busy, 1'b1);
        check("r_n1_start", bus_m.o_tx_start, 1'b0);
        check("r_n1_run", bus_m.o_run, 1'b0);
        tick();
        check("r_n2_run", bus_m.o_run, 1'b1);
        check("r_n2_start", bus_m.o_tx_start, 1'b1);
        check("r_n2_data", bus_m.o_tx_data, 8'h52);
        tick();
        check("r_n3_start", bus_m.o_tx_start, 1'b0);
        repeat (17) tick();
        check("r_n20_busy", bus_m.o_busy, 1'b1);
        pulse_tx_done();
        check("r_n21_busy", bus_m.o_busy, 1'b0);

        // 'C' -> one-cycle clear, run unchanged
        send(8'h43);
        check("c_n1_clear", bus_m.o_clear, 1'b0);
        tick();
        check("c_n2_clear", bus_m.o_clear, 1'b1);
        check("c_n2_run", bus_m.o_run, 1'b1);
        check("c_n2_data", bus_m.o_tx_data, 8'h43);
        check("c_n2_start", bus_m.o_tx_start, 1'b1);
        tick();
        check("c_n3_clear", bus_m.o_clear, 1'b0);
        pulse_tx_done();
        check("c_done_busy", bus_m.o_busy, 1'b0);

        // 'A' -> error reply
        send(8'h41);
        tick();
        check("a_data", bus_m.o_tx_data, 8'h3F);
        check("a_run", bus_m.o_run, 1'b1);
        check("a_clear", bus_m.o_clear, 1'b0);
        check("a_start", bus_m.o_tx_start, 1'b1);
        tick();
        pulse_tx_done();
        check("a_done_busy", bus_m.o_busy, 1'b0);

        // 'R', then 'S' buffered, 'C' dropped with overrun
        send(8'h52);
        tick();
        check("ov_r_data", bus_m.o_tx_data, 8'h52);
        send(8'h53);
        check("ov_after_s", bus_m.o_overrun, 1'b0);
        send(8'h43);
        check("ov_pulse", bus_m.o_overrun, 1'b1);
        tick();
        check("ov_pulse_end", bus_m.o_overrun, 1'b0);
        pulse_tx_done();
        check("ov_idle_busy", bus_m.o_busy, 1'b0);
        tick();
        check("ov_exec_busy", bus_m.o_busy, 1'b1);
        tick();
        check("ov_s_run", bus_m.o_run, 1'b0);
        check("ov_s_start", bus_m.o_tx_start, 1'b1);
        check("ov_s_data", bus_m.o_tx_data, 8'h53);
        check("ov_s_clear", bus_m.o_clear, 1'b0);
        tick();
        pulse_tx_done();
        tick();
        check("ov_c_dropped", bus_m.o_busy, 1'b0);

        // Timeout on the TX_TIMEOUT=16 instance with 'T'
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        send(8'h54);
        tick();
        check("to_run", bus_t.o_run, 1'b1);
        check("to_start", bus_t.o_tx_start, 1'b1);
        check("to_data", bus_t.o_tx_data, 8'h52);
        repeat (15) tick();
        check("to_n17_timeout", bus_t.o_tx_timeout, 1'b0);
        check("to_n17_busy", bus_t.o_busy, 1'b1);
        tick();
        check("to_n18_timeout", bus_t.o_tx_timeout, 1'b1);
        check("to_n18_busy", bus_t.o_busy, 1'b0);
        tick();
        check("to_n19_timeout", bus_t.o_tx_timeout, 1'b0);
        pulse_tx_done();
        check("to_late_busy", bus_t.o_busy, 1'b0);
        check("to_late_start", bus_t.o_tx_start, 1'b0);
        check("to_late_run", bus_t.o_run, 1'b1);

        // Reset during WAIT_TX with a pending byte
        send(8'h52);
        tick();
        check("rw_run", bus_m.o_run, 1'b1);
        send(8'h53);
        reset = 1'b0;
        tick();
        check("rw_run0", bus_m.o_run, 1'b0);
        check("rw_busy0", bus_m.o_busy, 1'b0);
        check("rw_start0", bus_m.o_tx_start, 1'b0);
        check("rw_data0", bus_m.o_tx_data, 8'h00);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | bus_m.o_tx_start | bus_m.o_busy;
        end
        check("rw_no_activity", seen, 1'b0);

        // REPLY_EN=0 instance: 'r' -> run at n+2, never any tx_start
        send(8'h72);
        check("nr_n1_run", bus_n.o_run, 1'b0);
        tick();
        check("nr_n2_run", bus_n.o_run, 1'b1);
        check("nr_n2_busy", bus_n.o_busy, 1'b0);
        repeat (3) tick();
        check("nr_no_start", nr_start_seen, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
